// File: rtl/mul_add_seq.sv
// Sequential shift-and-add unit: numerator = quotient*denominator + remain, one multiplier bit per cycle.
// Define MUL_ADD_SEQ_OVF_EN to add an ovf output flagging result bits lost to N_WIDTH truncation.
module mul_add_seq #(
  parameter int Q_WIDTH = 10,
  parameter int D_WIDTH = 8,
  parameter int N_WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [Q_WIDTH-1:0] quotient,
  input  logic [D_WIDTH-1:0] denominator,
  input  logic [D_WIDTH-1:0] remain,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_WIDTH-1:0] numerator
`ifdef MUL_ADD_SEQ_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int AW = Q_WIDTH + D_WIDTH;
  localparam int CW = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_reg, state_next;
  logic [AW-1:0]       acc_reg, mcand_reg;
  logic [Q_WIDTH-1:0]  mplier_reg;
  logic [CW-1:0]       count_reg;
  logic                last_step;

  assign last_step = (count_reg == CW'(Q_WIDTH - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Operands are zero-extended to the full product width so partial sums never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else if (state_reg == IDLE && in_valid) begin
      acc_reg    <= {{Q_WIDTH{1'b0}}, remain};
      mcand_reg  <= {{Q_WIDTH{1'b0}}, denominator};
      mplier_reg <= quotient;
      count_reg  <= '0;
    end else if (state_reg == BUSY) begin
      if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + CW'(1);
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign numerator = acc_reg[N_WIDTH-1:0];

`ifdef MUL_ADD_SEQ_OVF_EN
  assign ovf = (state_reg == DONE) && (|acc_reg[AW-1:N_WIDTH]);
`endif

endmodule

// File: tb/tb_mul_add_seq.sv
// Self-checking bench for mul_add_seq: directed cases, backpressure, mid-run reset,
// back-to-back traffic and random operands against an arithmetic reference model.
module tb_mul_add_seq;

  localparam int QW = 10;
  localparam int DW = 8;
  localparam int NW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [QW-1:0] quotient = '0;
  logic [DW-1:0] denominator = '0;
  logic [DW-1:0] remain = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NW-1:0] numerator;
`ifdef MUL_ADD_SEQ_OVF_EN
  logic          ovf;
`endif

  int total = 0;
  int bad = 0;

  mul_add_seq #(.Q_WIDTH(QW), .D_WIDTH(DW), .N_WIDTH(NW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .quotient(quotient), .denominator(denominator), .remain(remain),
    .out_valid(out_valid), .out_ready(out_ready), .numerator(numerator)
`ifdef MUL_ADD_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint model_full(input longint q, input longint d, input longint r);
    return q * d + r;
  endfunction

  // Wait for out_valid, returning number of edges taken since the accept edge.
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    if (!out_valid) chk({tag, "_timeout"}, 0, 1);
  endtask

  // One full transaction; hold > 0 stalls the consumer while noise is driven on the inputs.
  task automatic run_op(input string tag, input int q, input int d, input int r, input int hold);
    int     lat;
    longint full;
    full = model_full(q, d, r);
    in_valid = 1'b1; quotient = QW'(q); denominator = DW'(d); remain = DW'(r);
    out_ready = (hold == 0);
    step();
    chk({tag, "_busy_ready"}, in_ready, 0);
    quotient = QW'($urandom); denominator = DW'($urandom); remain = DW'($urandom);
    in_valid = 1'b0;
    wait_done(tag, lat);
    chk({tag, "_latency"}, lat, QW);
    chk({tag, "_num"}, numerator, full % (1 << NW));
`ifdef MUL_ADD_SEQ_OVF_EN
    chk({tag, "_ovf"}, ovf, (full >> NW) != 0);
`endif
    if (hold > 0) begin
      in_valid = 1'b1;
      repeat (hold) step();
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_num"}, numerator, full % (1 << NW));
      chk({tag, "_hold_ready"}, in_ready, 0);
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    step();
    chk({tag, "_idle_valid"}, out_valid, 0);
    chk({tag, "_idle_ready"}, in_ready, 1);
    out_ready = 1'b0;
    $display("txn %s q=%0d d=%0d r=%0d -> num=%0d lat=%0d", tag, q, d, r, numerator, lat);
  endtask

  initial begin
    int lat;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_numerator", numerator, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_numerator", numerator, 0);

    run_op("basic", 37, 7, 3, 0);
    run_op("q_zero", 0, 200, 5, 0);
    run_op("d_zero", 513, 0, 9, 0);
    run_op("max", 1023, 255, 255, 0);
    run_op("stall", 37, 7, 3, 20);

    // Reset asserted in the middle of a computation.
    in_valid = 1'b1; quotient = 10'd37; denominator = 8'd7; remain = 8'd3;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_numerator", numerator, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_after_ready", in_ready, 1);
    $display("txn midrst reset during BUSY cycle 4");
    run_op("after_rst", 37, 7, 3, 0);

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1; in_valid = 1'b1;
    quotient = 10'd12; denominator = 8'd12; remain = 8'd0;
    step();
    quotient = 10'd100; denominator = 8'd3; remain = 8'd1;
    wait_done("b2b_a", lat);
    chk("b2b_a_latency", lat, QW);
    chk("b2b_a_num", numerator, 144);
    $display("txn b2b_a q=12 d=12 r=0 -> num=%0d lat=%0d", numerator, lat);
    step();
    chk("b2b_gap_ready", in_ready, 1);
    step();
    chk("b2b_b_busy_ready", in_ready, 0);
    in_valid = 1'b0;
    wait_done("b2b_b", lat);
    chk("b2b_b_latency", lat, QW);
    chk("b2b_b_num", numerator, 301);
    $display("txn b2b_b q=100 d=3 r=1 -> num=%0d lat=%0d", numerator, lat);
    step();
    out_ready = 1'b0;

    for (int i = 0; i < 20; i++) begin
      run_op($sformatf("rnd%0d", i), int'($urandom_range(0, 1023)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             (i % 4 == 3) ? int'($urandom_range(1, 6)) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_add_seq.md
MUL_ADD_SEQ -- requirements
Module: mul_add_seq

Interface
REQ-001 SHALL have parameter Q_WIDTH, default 10: quotient operand width.
REQ-002 SHALL have parameter D_WIDTH, default 8: denominator and remainder operand width.
REQ-003 SHALL have parameter N_WIDTH, default 10: reconstructed numerator (result) width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  operand set presented.
REQ-007 SHALL have port in_ready  output  1  block can accept operands.
REQ-008 SHALL have port quotient  input  Q_WIDTH  multiplier operand.
REQ-009 SHALL have port denominator  input  D_WIDTH  multiplicand operand.
REQ-010 SHALL have port remain  input  D_WIDTH  addend operand.
REQ-011 SHALL have port out_valid  output  1  result holds a valid value.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port numerator  output  N_WIDTH  result, low N_WIDTH bits of quotient*denominator+remain.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 SHALL accept operands on a rising edge with state IDLE and in_valid=1: acc<=zero-extended remain, mcand<=zero-extended denominator, mplier<=quotient, count<=0, state<=BUSY.
REQ-016 SHALL keep acc and mcand Q_WIDTH+D_WIDTH bits wide so no intermediate overflow occurs.
REQ-017 SHALL, on each BUSY edge, add mcand to acc if mplier[0]=1, then shift mcand left 1, shift mplier right 1, increment count.
REQ-018 SHALL move BUSY->DONE on the edge where count reaches Q_WIDTH-1, giving out_valid high exactly Q_WIDTH edges after the accepting edge.
REQ-019 SHALL drive numerator from acc[N_WIDTH-1:0] and hold it stable while out_valid=1.
REQ-020 SHALL move DONE->IDLE on an edge with out_ready=1; with out_ready=0, SHALL remain in DONE indefinitely.
REQ-021 SHALL ignore in_valid and operand changes while in BUSY or DONE (in_ready=0); no input queuing.
REQ-022 SHALL produce result = remain for quotient=0 or denominator=0, still after Q_WIDTH cycles.
REQ-023 SHALL ignore out_ready outside DONE.

Reset
REQ-024 SHALL, on rst_n low at any time including mid-BUSY, immediately force state=IDLE, acc=0, mcand=0, mplier=0, count=0; in-flight operation is discarded.
REQ-025 SHALL drive in_ready=1, out_valid=0, numerator=0 while rst_n is low and after its release.

Configuration
REQ-026 SHALL, when macro MUL_ADD_SEQ_OVF_EN is defined, add output port ovf (1 bit) = OR of acc[Q_WIDTH+D_WIDTH-1:N_WIDTH], valid while out_valid=1, 0 otherwise and at reset.
REQ-027 SHALL, when MUL_ADD_SEQ_OVF_EN is undefined, omit port ovf and silently truncate the result to N_WIDTH bits.

Verification
REQ-028 Defaults, quotient=37, denominator=7, remain=3 -> out_valid 10 edges after accept, numerator=262, ovf=0.
REQ-029 quotient=0, denominator=200, remain=5 -> numerator=5 after 10 cycles; denominator=0, quotient=513, remain=9 -> numerator=9.
REQ-030 quotient=1023, denominator=255, remain=255 -> numerator=0, ovf=1 (macro defined); numerator=0, no ovf port (undefined).
REQ-031 Result 262 with out_ready=0 for 20 cycles -> out_valid, numerator held; in_ready=0; new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-032 rst_n pulsed low at BUSY cycle 4 -> immediate IDLE, out_valid=0, in_ready=1; next operation 37,7,3 -> 262 in 10 cycles.
REQ-033 Back-to-back: out_ready tied 1, in_valid tied 1 with 12,12,0 then 100,3,1 -> 144 then 301, one IDLE cycle between.
